// File: rtl/upcounter_2d_ctrl_pkg.sv
// Shared types and helpers for the two-digit BCD up-counting timer.
package upcounter_2d_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

  // Next BCD digit value, wrapping to zero once the rollover value is reached.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] v,
                                                 input logic [DIGIT_W-1:0] max);
    return (v >= max) ? BCD_ZERO : DIGIT_W'(v + 4'd1);
  endfunction

endpackage

// File: rtl/upcounter_2d_ctrl_upcounter.sv
// Single BCD digit up counter with synchronous load of init_val and a
// combinational carry out when incrementing past the rollover value.
module upcounter
  import upcounter_2d_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               increase,
  input  logic [DIGIT_W-1:0] init_val,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] val,
  output logic               carry
);

  always_ff @(posedge clk) begin
    if (rst) begin
      val <= init_val;
    end else if (increase) begin
      val <= bcd_inc(val, limit);
    end
  end

  assign carry = increase && (val == limit);

endmodule

// File: rtl/upcounter_2d_ctrl.sv
// Two-digit BCD up-counting timer with start/pause/clear control.
// Optional macro UPCNT_WRAP_EN: wrap to 00 at the target with a one-cycle done pulse.
module upcounter_2d_ctrl
  import upcounter_2d_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT1   = 3,
  parameter int unsigned LIMIT0   = 0,
  parameter int unsigned TENS_MAX = 5,
  parameter int unsigned ONES_MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start_stop,
  input  logic               clear,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit0,
  output logic               running,
  output logic               done
);

  localparam logic [DIGIT_W-1:0] LIMIT1_D   = DIGIT_W'(LIMIT1);
  localparam logic [DIGIT_W-1:0] LIMIT0_D   = DIGIT_W'(LIMIT0);
  localparam logic [DIGIT_W-1:0] TENS_MAX_D = DIGIT_W'(TENS_MAX);
  localparam logic [DIGIT_W-1:0] ONES_MAX_D = DIGIT_W'(ONES_MAX);

  state_t             state;
  logic               count_en;
  logic               carry0;
  logic               carry1;
  logic               hit;
  logic               wrap_load;
  logic               digit_load;
  logic [DIGIT_W-1:0] next1;
  logic [DIGIT_W-1:0] next0;

  // Counting happens only in RUN; clear overrides a same-cycle tick.
  assign count_en = tick && (state == RUN) && !clear;

  // Look ahead at the post-tick value so the target is caught on the edge it appears.
  always_comb begin
    next0 = bcd_inc(digit0, ONES_MAX_D);
    next1 = carry0 ? bcd_inc(digit1, TENS_MAX_D) : digit1;
    hit   = count_en && (next1 == LIMIT1_D) && (next0 == LIMIT0_D);
  end

`ifdef UPCNT_WRAP_EN
  assign wrap_load = hit;
`else
  assign wrap_load = 1'b0;
`endif

  assign digit_load = rst || clear || wrap_load;

  upcounter u_ones (
    .clk      (clk),
    .rst      (digit_load),
    .increase (count_en),
    .init_val (BCD_ZERO),
    .limit    (ONES_MAX_D),
    .val      (digit0),
    .carry    (carry0)
  );

  upcounter u_tens (
    .clk      (clk),
    .rst      (digit_load),
    .increase (carry0),
    .init_val (BCD_ZERO),
    .limit    (TENS_MAX_D),
    .val      (digit1),
    .carry    (carry1)
  );

  // Tens carry-out has no consumer; the tens digit simply wraps.
  logic unused_carry1;
  assign unused_carry1 = carry1;

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
`ifdef UPCNT_WRAP_EN
      done <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
`ifdef UPCNT_WRAP_EN
          if (hit) begin
            done <= 1'b1;
          end
          if (start_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
`else
          if (hit) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (start_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
`endif
        end
        PAUSE: begin
          if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upcounter_2d_ctrl.sv
// Directed bench for upcounter_2d_ctrl: vector table plus hand-written sequences.
module tb_upcounter_2d_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       start_stop;
  logic       clear;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       running;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  upcounter_2d_ctrl #(
`ifdef UPCNT_WRAP_EN
    .LIMIT1   (5),
    .LIMIT0   (9),
`else
    .LIMIT1   (3),
    .LIMIT0   (0),
`endif
    .TENS_MAX (5),
    .ONES_MAX (9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
    .digit1     (digit1),
    .digit0     (digit0),
    .running    (running),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       clear;
    logic       start_stop;
    logic       tick;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       running;
    logic       done;
    string      name;
  } vec_t;

  vec_t vecs [15];

  // Drive one cycle of inputs, then check outputs just after the edge.
  task automatic step(input logic r, input logic c, input logic s, input logic t,
                      input logic [3:0] e1, input logic [3:0] e0,
                      input logic er, input logic ed, input string name);
    @(negedge clk);
    rst = r; clear = c; start_stop = s; tick = t;
    @(posedge clk);
    #1;
    n_checks++;
    if ({digit1, digit0, running, done} !== {e1, e0, er, ed}) begin
      n_fail++;
      $display("FAIL %s: got d=%0d%0d running=%b done=%b, expected d=%0d%0d running=%b done=%b",
               name, digit1, digit0, running, done, e1, e0, er, ed);
    end
    @(negedge clk);
    rst = 1'b0; clear = 1'b0; start_stop = 1'b0; tick = 1'b0;
  endtask

  task automatic tick_to(input int n, input logic er, input logic ed, input string name);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'(n / 10), 4'(n % 10), er, ed, name);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start_stop = 1'b0; tick = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "reset"};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "idle_tick"};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, "idle_ss_tick"};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0, "run_01"};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0, "run_02"};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 1'b1, 1'b0, "run_03"};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd4, 1'b1, 1'b0, "run_04"};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5, 1'b1, 1'b0, "run_05"};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd6, 1'b1, 1'b0, "run_06"};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 1'b1, 1'b0, "run_07"};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd8, 1'b0, 1'b0, "run_ss_tick_08"};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd8, 1'b0, 1'b0, "pause_tick"};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0, "resume"};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9, 1'b1, 1'b0, "run_09"};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, "ones_carry_10"};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].clear, vecs[i].start_stop, vecs[i].tick,
           vecs[i].d1, vecs[i].d0, vecs[i].running, vecs[i].done, vecs[i].name);
    end

    // Pause at 12, ticks ignored, resume to 13.
    tick_to(11, 1'b1, 1'b0, "run_11");
    tick_to(12, 1'b1, 1'b0, "run_12");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0, "pause_12");
    for (int i = 0; i < 4; i++) tick_to(12, 1'b0, 1'b0, "paused_hold_12");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, "resume_12");
    for (int n = 13; n <= 15; n++) tick_to(n, 1'b1, 1'b0, "run_13_15");

    // Clear with a simultaneous tick at 15.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "clear_tick_15");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "start_after_clear");
    for (int n = 1; n <= 22; n++) tick_to(n, 1'b1, 1'b0, "count_to_22");
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "reset_mid_22");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "start_after_reset");

`ifdef UPCNT_WRAP_EN
    for (int n = 1; n <= 58; n++) tick_to(n, 1'b1, 1'b0, "count_to_58");
    tick_to(0, 1'b1, 1'b1, "wrap_to_00");
    tick_to(1, 1'b1, 1'b0, "after_wrap_01");
`else
    for (int n = 1; n <= 30; n++) tick_to(n, (n < 30), (n == 30), "count_to_30");
    for (int i = 0; i < 5; i++) tick_to(30, 1'b0, 1'b1, "done_hold_30");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 1'b1, "done_ss_ignored");
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "clear_from_done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
